// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// Turns the PS/2 receiver's scan-code byte strobes (set 2) into Enigma key
// events: letters A-Z as 0-25, ENTER as 26, BACKSPACE as 27.
// Break codes, extended (E0) keys and typematic auto-repeat produce no event.
// Events are queued in a first-word-fall-through FIFO with a valid/ready
// handshake toward the stepping logic. A sticky flag records any event that
// was lost because the FIFO was full.
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       key_rdy,
   input  logic [7:0] key_out,
   output logic       ev_valid,
   output logic [4:0] ev_code,
   input  logic       ev_ready,
   output logic       overflow
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } pfx_state_e;

   // Scan code set 2 lookup: returns {hit, event code}.
   function automatic logic [5:0] decode_set2(input logic [7:0] code);
      logic [5:0] res;
      case (code)
         8'h1C:   res = {1'b1, 5'd0};
         8'h32:   res = {1'b1, 5'd1};
         8'h21:   res = {1'b1, 5'd2};
         8'h23:   res = {1'b1, 5'd3};
         8'h24:   res = {1'b1, 5'd4};
         8'h2B:   res = {1'b1, 5'd5};
         8'h34:   res = {1'b1, 5'd6};
         8'h33:   res = {1'b1, 5'd7};
         8'h43:   res = {1'b1, 5'd8};
         8'h3B:   res = {1'b1, 5'd9};
         8'h42:   res = {1'b1, 5'd10};
         8'h4B:   res = {1'b1, 5'd11};
         8'h3A:   res = {1'b1, 5'd12};
         8'h31:   res = {1'b1, 5'd13};
         8'h44:   res = {1'b1, 5'd14};
         8'h4D:   res = {1'b1, 5'd15};
         8'h15:   res = {1'b1, 5'd16};
         8'h2D:   res = {1'b1, 5'd17};
         8'h1B:   res = {1'b1, 5'd18};
         8'h2C:   res = {1'b1, 5'd19};
         8'h3C:   res = {1'b1, 5'd20};
         8'h2A:   res = {1'b1, 5'd21};
         8'h1D:   res = {1'b1, 5'd22};
         8'h22:   res = {1'b1, 5'd23};
         8'h35:   res = {1'b1, 5'd24};
         8'h1A:   res = {1'b1, 5'd25};
         8'h5A:   res = {1'b1, 5'd26};
         8'h66:   res = {1'b1, 5'd27};
         default: res = {1'b0, 5'd0};
      endcase
      return res;
   endfunction

   // Prefix FSM and repeat filter state
   pfx_state_e state_q, state_d;
   logic [7:0] held_code_q, held_code_d;
   logic       held_vld_q, held_vld_d;

   // Decoder to FIFO
   logic [5:0] decoded_s;
   logic       hit_s;
   logic [4:0] code_s;
   logic       push_s;
   logic [4:0] push_code_s;

   // FIFO state
   logic [4:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_next_s;
   logic [CW-1:0] count_q, count_d;
   logic [4:0]    head_q, head_d;
   logic          valid_q, valid_d;
   logic          ovf_q, ovf_d;
   logic          pop_s;
   logic          full_s;
   logic          accept_s;

   assign decoded_s = decode_set2(key_out);
   assign hit_s     = decoded_s[5];
   assign code_s    = decoded_s[4:0];

   // Prefix FSM state and repeat-filter registers
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q     <= ST_IDLE;
         held_code_q <= 8'h00;
         held_vld_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         held_code_q <= held_code_d;
         held_vld_q  <= held_vld_d;
      end
   end

   // Byte interpretation: prefix tracking, decode, auto-repeat suppression
   always_comb begin
      state_d     = state_q;
      held_code_d = held_code_q;
      held_vld_d  = held_vld_q;
      push_s      = 1'b0;
      push_code_s = 5'd0;
      if (key_rdy) begin
         case (state_q)
            ST_IDLE: begin
               if (key_out == 8'hF0) begin
                  state_d = ST_BRK;
               end else if (key_out == 8'hE0) begin
                  state_d = ST_EXT;
               end else if (hit_s) begin
                  if (held_vld_q && (key_out == held_code_q)) begin
                     push_s = 1'b0;          // typematic repeat of the held key
                  end else begin
                     push_s      = 1'b1;
                     push_code_s = code_s;
                     held_code_d = key_out;
                     held_vld_d  = 1'b1;
                  end
               end else begin
                  push_s = 1'b0;             // unlisted make: held state kept
               end
            end
            ST_BRK: begin
               // Releasing the held key re-arms it; other releases change nothing.
               if (held_vld_q && (key_out == held_code_q)) begin
                  held_vld_d = 1'b0;
               end else begin
                  held_vld_d = held_vld_q;
               end
               state_d = ST_IDLE;
            end
            ST_EXT: begin
               if (key_out == 8'hF0) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_EXT_BRK: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // FIFO control: pointers, occupancy, registered head and flags
   always_comb begin
      pop_s     = valid_q & ev_ready;
      full_s    = (count_q == DEPTH_C);
      accept_s  = push_s & (~full_s | pop_s);
      rd_next_s = rd_ptr_q + PW'(1);
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      head_d    = head_q;
      ovf_d     = ovf_q | (push_s & full_s & ~pop_s);

      if (pop_s) begin
         rd_ptr_d = rd_next_s;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      if (accept_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      case ({accept_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // The pushed byte becomes the head when the FIFO is (or becomes) empty.
      if (accept_s && ((count_q == CW'(0)) || (pop_s && (count_q == CW'(1))))) begin
         head_d = push_code_s;
      end else if (pop_s && (count_q > CW'(1))) begin
         head_d = mem_q[rd_next_s];
      end else if (pop_s) begin
         head_d = 5'd0;
      end else begin
         head_d = head_q;
      end

      valid_d = (count_d != CW'(0));
   end

   // FIFO control registers
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= 5'd0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   // FIFO storage; contents are only meaningful behind the occupancy count
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem_q[wr_ptr_q] <= push_code_s;
      end
   end

   assign ev_valid = valid_q;
   assign ev_code  = head_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
// Directed scenarios followed by random byte traffic, all checked against a
// queue-based reference model of the key decoder and its event FIFO.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

   localparam int DEPTH = 4;

   logic       clk;
   logic       rst_l;
   logic       key_rdy;
   logic [7:0] key_out;
   logic       ev_valid;
   logic [4:0] ev_code;
   logic       ev_ready;
   logic       overflow;

   int checks;
   int errors;

   // Reference model state
   int         q_m[$];
   bit         ovf_m;
   bit         after_f0_m;
   bit         after_e0_m;
   bit         after_e0f0_m;
   bit         held_m;
   logic [7:0] held_code_m;
   logic [7:0] tbl [28] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                            8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                            8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                            8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h5A, 8'h66};

   ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_l    (rst_l),
      .key_rdy  (key_rdy),
      .key_out  (key_out),
      .ev_valid (ev_valid),
      .ev_code  (ev_code),
      .ev_ready (ev_ready),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lookup(input logic [7:0] b);
      for (int i = 0; i < 28; i++) begin
         if (tbl[i] == b) return i;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q_m.delete();
      ovf_m        = 1'b0;
      after_f0_m   = 1'b0;
      after_e0_m   = 1'b0;
      after_e0f0_m = 1'b0;
      held_m       = 1'b0;
      held_code_m  = 8'h00;
   endtask

   // What one clock edge does, given the inputs presented before it.
   task automatic model_edge(input logic kr, input logic [7:0] kb, input logic rdy);
      int  ev;
      bit  was_full;
      bit  pop;
      ev = -1;
      if (kr) begin
         if (after_f0_m) begin
            if (held_m && kb == held_code_m) held_m = 1'b0;
            after_f0_m = 1'b0;
         end else if (after_e0f0_m) begin
            after_e0f0_m = 1'b0;
         end else if (after_e0_m) begin
            after_e0_m   = 1'b0;
            after_e0f0_m = (kb == 8'hF0);
         end else if (kb == 8'hF0) begin
            after_f0_m = 1'b1;
         end else if (kb == 8'hE0) begin
            after_e0_m = 1'b1;
         end else if (lookup(kb) >= 0) begin
            if (!(held_m && kb == held_code_m)) begin
               ev          = lookup(kb);
               held_m      = 1'b1;
               held_code_m = kb;
            end
         end
      end
      was_full = (q_m.size() == DEPTH);
      pop      = (q_m.size() > 0) && rdy;
      if (pop) void'(q_m.pop_front());
      if (ev >= 0) begin
         if (!was_full || pop) q_m.push_back(ev);
         else ovf_m = 1'b1;
      end
   endtask

   task automatic compare_all();
      check("ev_valid", ev_valid, (q_m.size() != 0));
      if (q_m.size() != 0) check("ev_code", ev_code, q_m[0]);
      check("overflow", overflow, ovf_m);
   endtask

   // One clock cycle: present inputs, let the edge happen, compare #1 later.
   task automatic cyc(input logic kr, input logic [7:0] kb, input logic rdy);
      key_rdy  = kr;
      key_out  = kr ? kb : 8'($urandom);
      ev_ready = rdy;
      @(posedge clk);
      model_edge(kr, kb, rdy);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      key_rdy  = 1'b0;
      ev_ready = 1'b0;
      #2;
      rst_l = 1'b0;
      #1;
      check("rst_valid", ev_valid, 1'b0);
      check("rst_code", ev_code, 5'd0);
      check("rst_ovf", overflow, 1'b0);
      model_clear();
      @(negedge clk);
      rst_l = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] b;
      int r;
      checks   = 0;
      errors   = 0;
      rst_l    = 1'b1;
      key_rdy  = 1'b0;
      key_out  = 8'h00;
      ev_ready = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      do_reset();

      // 1: A make/break -> single event 0, visible the cycle after the strobe
      cyc(1'b1, 8'h1C, 1'b0);
      check("t1_valid_next", ev_valid, 1'b1);
      check("t1_code", ev_code, 5'd0);
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'hF0, 1'b0);
      cyc(1'b1, 8'h1C, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      check("t1_single", ev_valid, 1'b0);

      // 2: Q with auto-repeat, release, re-press
      do_reset();
      cyc(1'b1, 8'h15, 1'b0);
      cyc(1'b1, 8'h15, 1'b0);
      cyc(1'b1, 8'h15, 1'b0);
      cyc(1'b1, 8'hF0, 1'b0);
      cyc(1'b1, 8'h15, 1'b0);
      cyc(1'b1, 8'h15, 1'b0);
      check("t2_first", ev_code, 5'd16);
      cyc(1'b0, 8'h00, 1'b1);
      check("t2_second_valid", ev_valid, 1'b1);
      check("t2_second", ev_code, 5'd16);
      cyc(1'b0, 8'h00, 1'b1);
      check("t2_only_two", ev_valid, 1'b0);

      // 3: keypad ENTER (E0 5A) ignored, main ENTER emits 26
      do_reset();
      cyc(1'b1, 8'hE0, 1'b0);
      cyc(1'b1, 8'h5A, 1'b0);
      check("t3_ext_ignored", ev_valid, 1'b0);
      cyc(1'b1, 8'hE0, 1'b0);
      cyc(1'b1, 8'hF0, 1'b0);
      cyc(1'b1, 8'h5A, 1'b0);
      cyc(1'b1, 8'h5A, 1'b0);
      check("t3_enter", ev_code, 5'd26);
      cyc(1'b0, 8'h00, 1'b1);
      check("t3_one_event", ev_valid, 1'b0);

      // 4: five makes into a 4-deep FIFO, then drain in order
      do_reset();
      cyc(1'b1, 8'h32, 1'b0);
      cyc(1'b1, 8'h21, 1'b0);
      cyc(1'b1, 8'h23, 1'b0);
      cyc(1'b1, 8'h24, 1'b0);
      check("t4_not_yet_ovf", overflow, 1'b0);
      cyc(1'b1, 8'h2B, 1'b0);
      check("t4_ovf", overflow, 1'b1);
      check("t4_head", ev_code, 5'd1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);
      check("t4_drained", ev_valid, 1'b0);
      check("t4_ovf_sticky", overflow, 1'b1);

      // 5: full FIFO, pop and push in the same cycle
      do_reset();
      cyc(1'b1, 8'h34, 1'b0);
      cyc(1'b1, 8'h33, 1'b0);
      cyc(1'b1, 8'h43, 1'b0);
      cyc(1'b1, 8'h3B, 1'b0);
      cyc(1'b1, 8'h42, 1'b1);
      check("t5_no_ovf", overflow, 1'b0);
      check("t5_head", ev_code, 5'd7);
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
      check("t5_tail", ev_code, 5'd10);
      cyc(1'b0, 8'h00, 1'b1);
      check("t5_empty", ev_valid, 1'b0);

      // 6: reset between F0 and the code byte, then reset mid-drain
      do_reset();
      cyc(1'b1, 8'hF0, 1'b0);
      do_reset();
      cyc(1'b1, 8'h1C, 1'b0);
      check("t6_after_rst", ev_code, 5'd0);
      check("t6_after_rst_v", ev_valid, 1'b1);
      cyc(1'b1, 8'h1B, 1'b0);
      cyc(1'b1, 8'h23, 1'b1);
      do_reset();

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 19);
         if (r < 6)       b = tbl[$urandom_range(0, 4)];
         else if (r < 8)  b = 8'hF0;
         else if (r < 9)  b = 8'hE0;
         else if (r < 11) b = tbl[$urandom_range(0, 27)];
         else if (r < 12) b = 8'($urandom);
         else             b = 8'h00;
         if (r < 12) cyc(1'b1, b, 1'($urandom_range(0, 2) == 0));
         else        cyc(1'b0, 8'h00, 1'($urandom_range(0, 2) == 0));
         if ($urandom_range(0, 299) == 0) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
